// File: rtl/grf_wb_scoreboard_pkg.sv
// Shared constants and helpers for the general register file and its write-back scoreboard.
package grf_wb_scoreboard_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic [AW-1:0] REG_RA   = 5'd31;

  // True when an enabled port targets address b; $0 never matches.
  function automatic logic addr_hit(input logic en, input logic [AW-1:0] a,
                                    input logic [AW-1:0] b);
    return en && (a == b) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/grf_core.sv
// Register storage with one write port, two combinational read ports, $0 rule and
// same-cycle write-through bypass.
module grf_core
  import grf_wb_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data
);

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && (wb_addr != REG_ZERO)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    if (addr_hit(wb_en, wb_addr, rs_addr)) begin
      rs_data = wb_data;
    end
    if (rs_addr == REG_ZERO) begin
      rs_data = '0;
    end

    rt_data = regs_q[rt_addr];
    if (addr_hit(wb_en, wb_addr, rt_addr)) begin
      rt_data = wb_data;
    end
    if (rt_addr == REG_ZERO) begin
      rt_data = '0;
    end
  end

endmodule

// File: rtl/grf_wb_scoreboard.sv
// General register file with a per-register pending-write scoreboard: issue sets a busy bit,
// write-back clears it, and a retiring register is reported not busy because it is bypassed.
module grf_wb_scoreboard
  import grf_wb_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          rs_busy,
  output logic          rt_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  grf_core u_core (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  // Issue is applied after retire so the newer producer wins on a same-address collision.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && (wb_addr != REG_ZERO)) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (iss_en && (iss_addr != REG_ZERO)) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs_busy = (rs_addr != REG_ZERO) && busy_q[rs_addr] && !addr_hit(wb_en, wb_addr, rs_addr);
  assign rt_busy = (rt_addr != REG_ZERO) && busy_q[rt_addr] && !addr_hit(wb_en, wb_addr, rt_addr);

endmodule
